// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: NOP encoding, reset PC default and
// the IF/ID payload types used by the fetch stage.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Payload handed to decode.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
  } ifid_t;

  // One fetched instruction waiting in the fetch buffer.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, PC: 32'h0, PCPlus4: 32'h0};

  // Redirect targets are forced to word alignment.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifid_if.sv
// IF/ID pipeline register bundle; fetch drives it, decode reads it.
interface ifid_if;
  riscv_pkg::ifid_t data;

  modport wr (output data);
  modport rd (input  data);
endinterface

// File: rtl/fetch_fifo.sv
// Two-entry in-order FIFO with synchronous clear. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign dout    = slot[rd_ptr];

  // NOTE: the data slots carry no reset; occupancy is tracked only by count,
  // so stale slot contents are never observed as valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      slot[wr_ptr] <= din;
    end
  end

  // NOTE: state is updated with <= so every flop samples pre-edge values,
  // independent of the order in which always blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues word fetches, tracks in-flight PCs, buffers
// returned instructions and feeds the IF/ID register, with branch redirect.
module if_stage import riscv_pkg::*; #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  ifid_if.wr          ifid,
  output logic        ValidD
);

  logic [31:0]  pcf;
  logic [1:0]   drop_cnt;
  logic [1:0]   pcq_count;
  logic [31:0]  pcq_head;
  logic [1:0]   fb_count;
  fetch_entry_t fb_head;
  fetch_entry_t fb_push_data;
  logic         req_fire;
  logic         rsp_keep;
  logic         fb_pop;
  ifid_t        ifid_q;
  ifid_t        ifid_next;
  logic         valid_q;
  logic         valid_next;

  // Outstanding counts every accepted request still owed a response, whether
  // it will be kept (PC queue) or discarded (drop count).
  assign imem_req_valid = reset && !StallF && !PCSrcE &&
                          ((3'(pcq_count) + 3'(drop_cnt) + 3'(fb_count)) < 3'd2);
  assign imem_req_addr  = pcf;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep     = imem_rsp_valid && (drop_cnt == 2'd0) && !PCSrcE;
  assign fb_push_data = '{instr: imem_rsp_data, pc: pcq_head};
  assign fb_pop       = !FlushD && !StallD && (fb_count != 2'd0);

  fetch_fifo #(.WIDTH(32)) u_pc_queue (
    .clk   (clk),
    .rst_n (reset),
    .clear (PCSrcE),
    .push  (req_fire),
    .din   (pcf),
    .pop   (rsp_keep),
    .dout  (pcq_head),
    .count (pcq_count)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t))) u_fetch_buf (
    .clk   (clk),
    .rst_n (reset),
    .clear (PCSrcE),
    .push  (rsp_keep),
    .din   (fb_push_data),
    .pop   (fb_pop),
    .dout  (fb_head),
    .count (fb_count)
  );

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ifid_next  = ifid_q;
    valid_next = valid_q;
    if (FlushD) begin
      ifid_next  = IFID_BUBBLE;
      valid_next = 1'b0;
    end else if (!StallD) begin
      if (fb_count != 2'd0) begin
        ifid_next  = '{instr: fb_head.instr, PC: fb_head.pc, PCPlus4: fb_head.pc + 32'd4};
        valid_next = 1'b1;
      end else begin
        ifid_next  = IFID_BUBBLE;
        valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcf      <= RESET_PC;
      drop_cnt <= 2'd0;
      ifid_q   <= IFID_BUBBLE;
      valid_q  <= 1'b0;
    end else begin
      // A redirect wins over StallF so the branch target is never lost.
      if (PCSrcE) begin
        pcf <= align_pc(PCTargetE);
      end else if (req_fire) begin
        pcf <= pcf + 32'd4;
      end

      // Every in-flight response at redirect time belongs to the wrong path;
      // one arriving in the redirect cycle itself is consumed right here.
      if (PCSrcE) begin
        drop_cnt <= pcq_count + drop_cnt - {1'b0, imem_rsp_valid};
      end else if (imem_rsp_valid && (drop_cnt != 2'd0)) begin
        drop_cnt <= drop_cnt - 2'd1;
      end

      ifid_q  <= ifid_next;
      valid_q <= valid_next;
    end
  end

  assign ifid.data = ifid_q;
  assign ValidD    = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a one-cycle in-order instruction memory
// whose responses can be held back to build up outstanding requests.
module tb_if_stage;
  import riscv_pkg::*;

  logic        clk            = 1'b0;
  logic        reset          = 1'b0;
  logic        StallF         = 1'b0;
  logic        StallD         = 1'b0;
  logic        FlushD         = 1'b0;
  logic        PCSrcE         = 1'b0;
  logic [31:0] PCTargetE      = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        ValidD;

  ifid_if ifid ();

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .StallF         (StallF),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ifid           (ifid),
    .ValidD         (ValidD)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] fired [$];
  logic [31:0] pend  [$];
  ifid_t       got   [$];
  bit          rsp_en = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h1357_0000;
  endfunction

  function automatic logic [31:0] fired_at(input int i);
    if (i < fired.size()) return fired[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
  endtask

  task automatic wait_valid(input string tag);
    int  cyc;
    bit  seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (ValidD === 1'b1) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // Decode-consumed stream from index start must be base, base+4, ... with
  // matching memory words.
  task automatic check_seq(input string tag, input int start, input logic [31:0] base);
    bit          ok;
    logic [31:0] pc;
    ifid_t       e;
    ok = (got.size() > start);
    for (int i = start; i < got.size(); i++) begin
      pc = base + 32'(4 * (i - start));
      e  = got[i];
      if (e.PC !== pc || e.instr !== mem_word(pc) || e.PCPlus4 !== pc + 32'd4) ok = 1'b0;
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  // Request / consumption monitor.
  always @(posedge clk) begin
    if (reset && imem_req_valid && imem_req_ready) begin
      fired.push_back(imem_req_addr);
      pend.push_back(imem_req_addr);
    end
    if (reset && ValidD && !StallD && !FlushD) got.push_back(ifid.data);
  end

  // Memory: answers one cycle after acceptance, in order, one per cycle.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      pend.delete();
      imem_rsp_valid = 1'b0;
    end else if (rsp_en && pend.size() != 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] hold;
    ifid_t       snap;
    int          nf;
    int          fm;
    int          gm;

    repeat (2) @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_validd",    32'(ValidD), 32'd0);
    check("rst_instr",     ifid.data.instr, 32'h0000_0013);
    check("rst_pc",        ifid.data.PC, 32'h0);
    check("rst_pcplus4",   ifid.data.PCPlus4, 32'h0);
    check("rst_req_addr",  imem_req_addr, 32'h0);

    // Reset release with a ready one-cycle memory.
    reset = 1'b1;
    wait_valid("first_valid");
    check("first_pc",      ifid.data.PC, 32'h0);
    check("first_instr",   ifid.data.instr, mem_word(32'h0));
    check("first_pcplus4", ifid.data.PCPlus4, 32'h4);
    repeat (3) @(negedge clk);
    check("fire0", fired_at(0), 32'h0);
    check("fire1", fired_at(1), 32'h4);
    check("fire2", fired_at(2), 32'h8);

    // Memory not ready for five cycles.
    imem_req_ready = 1'b0;
    hold = imem_req_addr;
    nf   = fired.size();
    repeat (5) begin
      @(negedge clk);
      check("ready0_addr_stable", imem_req_addr, hold);
    end
    check("ready0_no_fire", fired.size(), nf);
    check("ready0_drained",  32'(ValidD), 32'd0);
    imem_req_ready = 1'b1;

    // Decode stall for three cycles.
    wait_valid("pre_stall_valid");
    StallD = 1'b1;
    snap   = ifid.data;
    repeat (3) begin
      @(negedge clk);
      check("stalld_pc_held",    ifid.data.PC, snap.PC);
      check("stalld_instr_held", ifid.data.instr, snap.instr);
      check("stalld_valid_held", 32'(ValidD), 32'd1);
    end
    check("stalld_inflight", fired.size() - got.size() - int'(ValidD), 2);
    StallD = 1'b0;
    repeat (8) @(negedge clk);
    check_seq("seq_no_loss_dup", 0, 32'h0);

    // Redirect with two requests outstanding; one response lands in the
    // redirect cycle, the other one cycle later.
    rsp_en = 1'b0;
    repeat (4) @(negedge clk);
    check("redir_outstanding", pend.size(), 2);
    PCSrcE    = 1'b1;
    PCTargetE = 32'h100;
    FlushD    = 1'b1;
    rsp_en    = 1'b1;
    #2;
    check("redir_req_blocked", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    PCSrcE = 1'b0;
    FlushD = 1'b0;
    gm = got.size();
    fm = fired.size();
    check("redir_bubble", 32'(ValidD), 32'd0);
    wait_valid("redir_valid");
    check("redir_pc",      ifid.data.PC, 32'h100);
    check("redir_instr",   ifid.data.instr, mem_word(32'h100));
    check("redir_pcplus4", ifid.data.PCPlus4, 32'h104);
    check("redir_fire",    fired_at(fm), 32'h100);
    repeat (6) @(negedge clk);
    check_seq("redir_seq", gm, 32'h100);

    // Flush and stall together: flush wins.
    wait_valid("pre_flush_valid");
    FlushD = 1'b1;
    StallD = 1'b1;
    @(negedge clk);
    check("flush_instr",   ifid.data.instr, 32'h0000_0013);
    check("flush_valid",   32'(ValidD), 32'd0);
    check("flush_pc",      ifid.data.PC, 32'h0);
    check("flush_pcplus4", ifid.data.PCPlus4, 32'h0);
    FlushD = 1'b0;
    StallD = 1'b0;

    // Redirect under StallF to an unaligned top-of-memory target, then wrap.
    StallF    = 1'b1;
    PCSrcE    = 1'b1;
    PCTargetE = 32'hFFFF_FFFF;
    FlushD    = 1'b1;
    #2;
    check("stallf_redir_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    PCSrcE = 1'b0;
    FlushD = 1'b0;
    #1;
    check("redir_aligned_pcf", imem_req_addr, 32'hFFFF_FFFC);
    check("stallf_blocks",     32'(imem_req_valid), 32'd0);
    repeat (2) @(negedge clk);
    fm     = fired.size();
    StallF = 1'b0;
    wait_valid("wrap_valid");
    check("wrap_pc",      ifid.data.PC, 32'hFFFF_FFFC);
    check("wrap_instr",   ifid.data.instr, mem_word(32'hFFFF_FFFC));
    check("wrap_pcplus4", ifid.data.PCPlus4, 32'h0);
    repeat (2) @(negedge clk);
    check("wrap_fire0", fired_at(fm), 32'hFFFF_FFFC);
    check("wrap_fire1", fired_at(fm + 1), 32'h0);

    // Reset in the middle of fetching.
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("midrst_valid",    32'(ValidD), 32'd0);
    check("midrst_instr",    ifid.data.instr, 32'h0000_0013);
    check("midrst_req",      32'(imem_req_valid), 32'd0);
    check("midrst_pcf",      imem_req_addr, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    fm = fired.size();
    wait_valid("postrst_valid");
    check("postrst_pc",    ifid.data.PC, 32'h0);
    check("postrst_instr", ifid.data.instr, mem_word(32'h0));
    check("postrst_fire",  fired_at(fm), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
